// File: rtl/w5300_bus_arbiter_if.sv
// Signal bundle between w5300_bus_arbiter, its two requesters and the W5300 pins.
// master = the arbiter itself, slave = everything around it (requesters, pads, bench).
interface w5300_bus_arbiter_if;
    // requester A (register/config engine)
    logic        a_req;
    logic        a_we;
    logic [9:0]  a_addr;
    logic [15:0] a_wdata;
    logic        a_done;
    // requester B (socket data engine)
    logic        b_req;
    logic        b_we;
    logic [9:0]  b_addr;
    logic [15:0] b_wdata;
    logic        b_done;
    // shared results and status
    logic [15:0] rdata;
    logic        bus_ready;
    logic        irq;
    // W5300 side
    logic        int_n;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        data_oe;
    logic [9:0]  addr;
    logic        cs_n;
    logic        rd_n;
    logic        we_n;
    logic        reset_n;
    logic        rw_n;

    modport master (
        input  a_req, a_we, a_addr, a_wdata,
        input  b_req, b_we, b_addr, b_wdata,
        input  int_n, data_in,
        output a_done, b_done, rdata, bus_ready, irq,
        output data_out, data_oe, addr, cs_n, rd_n, we_n, reset_n, rw_n
    );

    modport slave (
        output a_req, a_we, a_addr, a_wdata,
        output b_req, b_we, b_addr, b_wdata,
        output int_n, data_in,
        input  a_done, b_done, rdata, bus_ready, irq,
        input  data_out, data_oe, addr, cs_n, rd_n, we_n, reset_n, rw_n
    );
endinterface

// File: rtl/w5300_bus_arbiter.sv
// Round-robin arbiter and cycle sequencer for the W5300 16-bit parallel bus,
// including the chip hardware-reset sequence and the int_n synchroniser.
module w5300_bus_arbiter #(
    parameter int unsigned T_SETUP  = 1,
    parameter int unsigned T_STROBE = 7,
    parameter int unsigned T_HOLD   = 2,
    parameter int unsigned RST_LOW  = 200,
    parameter int unsigned RST_WAIT = 1000000
) (
    input  logic                clk0,
    input  logic                rst,
    w5300_bus_arbiter_if.master bif
);

    typedef enum logic [2:0] {
        ST_RST_LO,
        ST_RST_WT,
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_DONE
    } state_t;

    // Every timed state counts 0 .. N-1 and leaves when the counter hits N-1.
    localparam logic [23:0] LAST_RST_LO = 24'(RST_LOW - 1);
    localparam logic [23:0] LAST_RST_WT = 24'(RST_WAIT - 1);
    localparam logic [23:0] LAST_SETUP  = 24'(T_SETUP - 1);
    localparam logic [23:0] LAST_STROBE = 24'(T_STROBE - 1);
    localparam logic [23:0] LAST_HOLD   = 24'(T_HOLD - 1);

    state_t      r_state;
    logic [23:0] r_cnt;
    logic        r_ptr_b;
    logic        r_gnt_b;
    logic        r_we;

    logic        r_cs_n;
    logic        r_rd_n;
    logic        r_we_n;
    logic        r_rw_n;
    logic        r_data_oe;
    logic [9:0]  r_addr;
    logic [15:0] r_data_out;
    logic [15:0] r_rdata;
    logic        r_a_done;
    logic        r_b_done;
    logic        r_bus_ready;
    logic        r_reset_n;

    logic        r_int_meta;
    logic        r_int_sync;

    logic        w_any_req;
    logic        w_pick_b;
    logic        w_sel_we;
    logic [9:0]  w_sel_addr;
    logic [15:0] w_sel_wdata;
    logic [23:0] w_limit;
    logic        w_cnt_last;

    // Pointer side wins a tie; a lone requester wins regardless of the pointer.
    assign w_any_req   = bif.a_req | bif.b_req;
    assign w_pick_b    = bif.b_req & (~bif.a_req | r_ptr_b);
    assign w_sel_we    = w_pick_b ? bif.b_we    : bif.a_we;
    assign w_sel_addr  = w_pick_b ? bif.b_addr  : bif.a_addr;
    assign w_sel_wdata = w_pick_b ? bif.b_wdata : bif.a_wdata;

    always_comb begin
        w_limit = '0;
        case (r_state)
            ST_RST_LO: w_limit = LAST_RST_LO;
            ST_RST_WT: w_limit = LAST_RST_WT;
            ST_SETUP:  w_limit = LAST_SETUP;
            ST_STROBE: w_limit = LAST_STROBE;
            ST_HOLD:   w_limit = LAST_HOLD;
            default:   w_limit = '0;
        endcase
    end

    assign w_cnt_last = (r_cnt == w_limit);

    always_ff @(posedge clk0 or posedge rst) begin
        if (rst) begin
            r_state     <= ST_RST_LO;
            r_cnt       <= '0;
            r_ptr_b     <= 1'b0;
            r_gnt_b     <= 1'b0;
            r_we        <= 1'b0;
            r_cs_n      <= 1'b1;
            r_rd_n      <= 1'b1;
            r_we_n      <= 1'b1;
            r_rw_n      <= 1'b1;
            r_data_oe   <= 1'b0;
            r_addr      <= '0;
            r_data_out  <= '0;
            r_rdata     <= '0;
            r_a_done    <= 1'b0;
            r_b_done    <= 1'b0;
            r_bus_ready <= 1'b0;
            r_reset_n   <= 1'b0;
        end else begin
            r_a_done <= 1'b0;
            r_b_done <= 1'b0;
            case (r_state)
                ST_RST_LO: begin
                    if (w_cnt_last) begin
                        r_state   <= ST_RST_WT;
                        r_cnt     <= '0;
                        r_reset_n <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 24'd1;
                    end
                end

                ST_RST_WT: begin
                    if (w_cnt_last) begin
                        r_state     <= ST_IDLE;
                        r_cnt       <= '0;
                        r_bus_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 24'd1;
                    end
                end

                ST_IDLE: begin
                    if (w_any_req) begin
                        r_state    <= ST_SETUP;
                        r_cnt      <= '0;
                        r_gnt_b    <= w_pick_b;
                        r_ptr_b    <= ~w_pick_b;
                        r_we       <= w_sel_we;
                        r_addr     <= w_sel_addr;
                        r_data_out <= w_sel_wdata;
                        r_cs_n     <= 1'b0;
                        r_rw_n     <= ~w_sel_we;
                        r_data_oe  <= w_sel_we;
                    end
                end

                ST_SETUP: begin
                    if (w_cnt_last) begin
                        r_state <= ST_STROBE;
                        r_cnt   <= '0;
                        if (r_we) begin
                            r_we_n <= 1'b0;
                        end else begin
                            r_rd_n <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 24'd1;
                    end
                end

                // Read data is taken on the same edge that raises rd_n.
                ST_STROBE: begin
                    if (w_cnt_last) begin
                        r_state <= ST_HOLD;
                        r_cnt   <= '0;
                        r_rd_n  <= 1'b1;
                        r_we_n  <= 1'b1;
                        if (!r_we) begin
                            r_rdata <= bif.data_in;
                        end
                    end else begin
                        r_cnt <= r_cnt + 24'd1;
                    end
                end

                ST_HOLD: begin
                    if (w_cnt_last) begin
                        r_state   <= ST_DONE;
                        r_cnt     <= '0;
                        r_cs_n    <= 1'b1;
                        r_rw_n    <= 1'b1;
                        r_data_oe <= 1'b0;
                        r_a_done  <= ~r_gnt_b;
                        r_b_done  <= r_gnt_b;
                    end else begin
                        r_cnt <= r_cnt + 24'd1;
                    end
                end

                // No arbitration here: the finished requester drops req on this edge.
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_RST_LO;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk0 or posedge rst) begin
        if (rst) begin
            r_int_meta <= 1'b1;
            r_int_sync <= 1'b1;
        end else begin
            r_int_meta <= bif.int_n;
            r_int_sync <= r_int_meta;
        end
    end

    assign bif.cs_n      = r_cs_n;
    assign bif.rd_n      = r_rd_n;
    assign bif.we_n      = r_we_n;
    assign bif.rw_n      = r_rw_n;
    assign bif.data_oe   = r_data_oe;
    assign bif.addr      = r_addr;
    assign bif.data_out  = r_data_out;
    assign bif.rdata     = r_rdata;
    assign bif.a_done    = r_a_done;
    assign bif.b_done    = r_b_done;
    assign bif.bus_ready = r_bus_ready;
    assign bif.reset_n   = r_reset_n;
    assign bif.irq       = ~r_int_sync;

endmodule

// File: tb/tb_w5300_bus_arbiter.sv
// Randomised scoreboard bench for w5300_bus_arbiter: stimulus pushes expected
// transactions, a bus monitor pops and checks them whenever a done appears.
module tb_w5300_bus_arbiter;

    localparam int TS     = 1;
    localparam int TST    = 7;
    localparam int TH     = 2;
    localparam int RLO    = 4;
    localparam int RWT    = 6;
    localparam int BUSLEN = TS + TST + TH;

    logic clk0 = 1'b0;
    logic rst  = 1'b1;
    always #5 clk0 = ~clk0;

    w5300_bus_arbiter_if bif();

    w5300_bus_arbiter #(
        .T_SETUP (TS),
        .T_STROBE(TST),
        .T_HOLD  (TH),
        .RST_LOW (RLO),
        .RST_WAIT(RWT)
    ) dut (
        .clk0(clk0),
        .rst (rst),
        .bif (bif)
    );

    typedef struct {
        bit          side;   // 0 = A, 1 = B
        bit          we;
        logic [9:0]  addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] mem [0:1023];
    bit          m_ptr;          // model round-robin pointer, 1 = B
    int          n_tests = 0;
    int          n_fail  = 0;
    bit          spacing_chk = 0;
    bit          prev_valid  = 0;

    // W5300 model: presents its register contents while rd_n is low.
    always_comb begin
        bif.data_in = 16'h0F0F;
        if (!bif.rd_n) bif.data_in = mem[bif.addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input bit side, input bit we, input logic [9:0] a, input logic [15:0] wd);
        exp_t e;
        e.side  = side;
        e.we    = we;
        e.addr  = a;
        e.wdata = wd;
        e.rdata = mem[a];
        return e;
    endfunction

    task automatic set_req(input bit side, input bit v, input exp_t e);
        if (side == 1'b0) begin
            bif.a_req = v; bif.a_we = e.we; bif.a_addr = e.addr; bif.a_wdata = e.wdata;
        end else begin
            bif.b_req = v; bif.b_we = e.we; bif.b_addr = e.addr; bif.b_wdata = e.wdata;
        end
    endtask

    task automatic wait_done(input bit side, input int limit);
        bit seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(posedge clk0); #1;
            seen = side ? bif.b_done : bif.a_done;
        end
        check(side ? "b_done_seen" : "a_done_seen", 32'(seen), 32'd1);
        if (side) bif.b_req = 1'b0; else bif.a_req = 1'b0;
    endtask

    task automatic single(input bit side, input bit we, input logic [9:0] a, input logic [15:0] wd);
        exp_t e;
        @(negedge clk0);
        e = mk(side, we, a, wd);
        sb.push_back(e);
        m_ptr = ~side;
        set_req(side, 1'b1, e);
        wait_done(side, 100);
    endtask

    task automatic contention(input int n);
        exp_t la[$];
        exp_t lb[$];
        bit first = m_ptr;
        for (int i = 0; i < n; i++) begin
            la.push_back(mk(1'b0, 1'($urandom), 10'($urandom), 16'($urandom)));
            lb.push_back(mk(1'b1, 1'($urandom), 10'($urandom), 16'($urandom)));
        end
        for (int i = 0; i < n; i++) begin
            sb.push_back(first ? lb[i] : la[i]);
            sb.push_back(first ? la[i] : lb[i]);
        end
        m_ptr = first;
        prev_valid  = 1'b0;
        spacing_chk = 1'b1;
        fork
            begin
                for (int i = 0; i < n; i++) begin
                    @(negedge clk0); set_req(1'b0, 1'b1, la[i]); wait_done(1'b0, 100);
                end
            end
            begin
                for (int i = 0; i < n; i++) begin
                    @(negedge clk0); set_req(1'b1, 1'b1, lb[i]); wait_done(1'b1, 100);
                end
            end
        join
        spacing_chk = 1'b0;
    endtask

    task automatic release_and_check_reset();
        int lo = 0;
        int wt = 0;
        @(negedge clk0);
        rst = 1'b0;
        #1;
        for (int i = 0; i < 100 && bif.reset_n === 1'b0; i++) begin
            lo++;
            @(negedge clk0);
        end
        check("reset_n_low_cycles", 32'(lo), 32'(RLO));
        for (int i = 0; i < 100 && bif.bus_ready !== 1'b1; i++) begin
            if (bif.reset_n === 1'b1) wt++;
            @(negedge clk0);
        end
        check("reset_wait_cycles", 32'(wt), 32'(RWT));
        check("bus_ready_up", 32'(bif.bus_ready), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cs_n"},     32'(bif.cs_n),      32'd1);
        check({tag, "_rd_n"},     32'(bif.rd_n),      32'd1);
        check({tag, "_we_n"},     32'(bif.we_n),      32'd1);
        check({tag, "_rw_n"},     32'(bif.rw_n),      32'd1);
        check({tag, "_data_oe"},  32'(bif.data_oe),   32'd0);
        check({tag, "_addr"},     32'(bif.addr),      32'd0);
        check({tag, "_data_out"}, 32'(bif.data_out),  32'd0);
        check({tag, "_rdata"},    32'(bif.rdata),     32'd0);
        check({tag, "_dones"},    32'({bif.a_done, bif.b_done}), 32'd0);
        check({tag, "_bus_ready"},32'(bif.bus_ready), 32'd0);
        check({tag, "_reset_n"},  32'(bif.reset_n),   32'd0);
    endtask

    // Bus monitor and scoreboard consumer.
    int          mon_cyc = 0, start_cyc = 0, strb_first = -1, rd_lo = 0, we_lo = 0;
    int          cs_len = 0, hi_run = 0, last_done = 0, n_txn = 0;
    bit          in_tx = 0, had_tx = 0, unstable = 0, bad_strb = 0;
    logic [9:0]  t_addr;
    logic        t_rw, t_oe;
    logic [15:0] t_wd;
    logic [15:0] m_rdata = 16'h0;

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk0);
            mon_cyc++;
            if (rst) begin
                in_tx = 0; had_tx = 0; hi_run = 0; m_rdata = 16'h0;
                continue;
            end
            if (!bif.cs_n) begin
                if (!in_tx) begin
                    in_tx = 1; start_cyc = mon_cyc; cs_len = 0; strb_first = -1;
                    rd_lo = 0; we_lo = 0; unstable = 0; bad_strb = 0;
                    t_addr = bif.addr; t_rw = bif.rw_n; t_oe = bif.data_oe; t_wd = bif.data_out;
                    check("bus_ready_at_start", 32'(bif.bus_ready), 32'd1);
                    if (had_tx) check("cs_high_gap_ge2", 32'(hi_run >= 2), 32'd1);
                end
                cs_len++;
                if (bif.addr !== t_addr || bif.rw_n !== t_rw || bif.data_oe !== t_oe) unstable = 1;
                if ((!bif.rd_n || !bif.we_n) && strb_first < 0) strb_first = mon_cyc - start_cyc;
                if (!bif.rd_n) rd_lo++;
                if (!bif.we_n) begin we_lo++; t_wd = bif.data_out; end
                if (!bif.rd_n && !bif.we_n) bad_strb = 1;
                hi_run = 0;
            end else begin
                if (!bif.rd_n || !bif.we_n) bad_strb = 1;
                in_tx = 0;
                hi_run++;
            end
            if (bif.a_done || bif.b_done) begin
                check("done_onehot", 32'(bif.a_done & bif.b_done), 32'd0);
                if (sb.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_done: a_done=%0b b_done=%0b with none outstanding, required no done",
                             bif.a_done, bif.b_done);
                end else begin
                    e = sb.pop_front();
                    check("grant_side",    32'(bif.b_done), 32'(e.side));
                    check("done_bus_idle", 32'({bif.cs_n, bif.data_oe, bif.rw_n}), 32'b101);
                    check("addr",          32'(t_addr), 32'(e.addr));
                    check("rw_n",          32'(t_rw), 32'(!e.we));
                    check("data_oe",       32'(t_oe), 32'(e.we));
                    check("ctrl_stable",   32'(unstable), 32'd0);
                    check("strobe_legal",  32'(bad_strb), 32'd0);
                    check("cs_low_len",    32'(cs_len), 32'(BUSLEN));
                    check("rd_low_len",    32'(rd_lo), e.we ? 32'd0 : 32'(TST));
                    check("we_low_len",    32'(we_lo), e.we ? 32'(TST) : 32'd0);
                    check("strobe_offset", 32'(strb_first), 32'(TS));
                    check("done_latency",  32'(mon_cyc - start_cyc), 32'(BUSLEN));
                    if (e.we) begin
                        check("data_out",   32'(t_wd), 32'(e.wdata));
                        check("rdata_kept", 32'(bif.rdata), 32'(m_rdata));
                    end else begin
                        check("rdata",      32'(bif.rdata), 32'(e.rdata));
                        m_rdata = e.rdata;
                    end
                    if (spacing_chk && prev_valid) check("b2b_spacing", 32'(mon_cyc - last_done), 32'(BUSLEN + 2));
                    prev_valid = 1; last_done = mon_cyc; had_tx = 1; n_txn++;
                    $display("[TB] txn %0d side=%s we=%0b addr=0x%03h wdata=0x%04h rdata=0x%04h",
                             n_txn, e.side ? "B" : "A", e.we, e.addr, e.wdata, bif.rdata);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int k;
        exp_t e;
        for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
        mem[10'h20E] = 16'hA5C3;
        bif.a_req = 0; bif.a_we = 0; bif.a_addr = '0; bif.a_wdata = '0;
        bif.b_req = 0; bif.b_we = 0; bif.b_addr = '0; bif.b_wdata = '0;
        bif.int_n = 1'b1;
        m_ptr = 1'b0;

        repeat (3) @(negedge clk0);
        check_reset_outputs("rst");
        check("rst_irq", 32'(bif.irq), 32'd0);
        release_and_check_reset();

        // Directed read and write from the test plan.
        single(1'b0, 1'b0, 10'h20E, 16'h0000);
        single(1'b1, 1'b1, 10'h008, 16'h1234);

        // Random singles with random idle gaps.
        for (int i = 0; i < 10; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk0);
            single(1'($urandom), 1'($urandom), 10'($urandom), 16'($urandom));
        end

        repeat (2) @(negedge clk0);
        contention(4);

        // Interrupt synchroniser.
        repeat (3) @(negedge clk0);
        bif.int_n = 1'b0;
        #1 check("irq_not_comb", 32'(bif.irq), 32'd0);
        k = 0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk0);
            if (bif.irq === 1'b1 && k == 0) k = i;
        end
        check("irq_assert_lag_2to3", 32'(k >= 2 && k <= 3), 32'd1);
        bif.int_n = 1'b1;
        k = 0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk0);
            if (bif.irq === 1'b0 && k == 0) k = i;
        end
        check("irq_release_lag_2to3", 32'(k >= 2 && k <= 3), 32'd1);

        // Reset in the middle of a write strobe: the write is dropped silently.
        @(negedge clk0);
        e = mk(1'b0, 1'b1, 10'h155, 16'hBEEF);
        set_req(1'b0, 1'b1, e);
        for (int i = 0; i < 30 && bif.we_n !== 1'b0; i++) @(negedge clk0);
        check("mid_strobe_reached", 32'(bif.we_n), 32'd0);
        @(negedge clk0); @(negedge clk0);
        #2 rst = 1'b1;
        #1 check_reset_outputs("midrst");
        bif.a_req = 1'b0;
        m_ptr = 1'b0;
        repeat (2) @(negedge clk0);

        // Request raised before bus_ready must be served once the sequence ends.
        e = mk(1'b0, 1'b0, 10'($urandom), 16'h0);
        sb.push_back(e);
        set_req(1'b0, 1'b1, e);
        m_ptr = 1'b1;
        release_and_check_reset();
        wait_done(1'b0, 100);

        repeat (2) @(negedge clk0);
        contention(2);

        repeat (5) @(negedge clk0);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
